// File: rtl/player_input_pkg.sv
// Shared definitions for the player button front-end: button count, FSM encoding and lamp
// constants used by player_input and its debounce sub-module.
package player_input_pkg;

    localparam int unsigned NUM_BUTTONS = 4;

    localparam logic [NUM_BUTTONS-1:0] LAMPS_ALL_ON  = '1;
    localparam logic [NUM_BUTTONS-1:0] LAMPS_ALL_OFF = '0;

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StReleaseWait
    } state_e;

    function automatic logic [NUM_BUTTONS-1:0] oneHot(input logic [1:0] idx);
        return NUM_BUTTONS'(1) << idx;
    endfunction

endpackage

// File: rtl/player_input_debounce.sv
// One button channel: 2-flop synchronizer followed by a saturating consecutive-mismatch
// counter that flips the stable level once the new value has persisted long enough.
module player_input_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic level
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_TICKS);

    logic [1:0]      syncQ;
    logic            levelQ;
    logic [CntW-1:0] cntQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            syncQ  <= '0;
            levelQ <= 1'b0;
            cntQ   <= '0;
        end else begin
            syncQ <= {syncQ[0], button};
            // Counter stops at CntMax: reaching it commits the new level and restarts.
            if (syncQ[1] != levelQ) begin
                if (cntQ == CntMax) begin
                    levelQ <= syncQ[1];
                    cntQ   <= '0;
                end else begin
                    cntQ <= cntQ + CntW'(1);
                end
            end else begin
                cntQ <= '0;
            end
        end
    end

    assign level = levelQ;

endmodule

// File: rtl/player_input.sv
// Player button front-end: debounces four colour buttons, accepts single clean presses while
// the player owns the turn, and drives the colour lamps from game, sequencer or player state.
module player_input
    import player_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   simonTurn,
    input  logic [1:0]             simonNum,
    input  logic                   simonPressed,
    input  logic                   gameOver,
    output logic [1:0]             playerNum,
    output logic                   playerPressed,
    output logic [NUM_BUTTONS-1:0] lamps
);

    logic [NUM_BUTTONS-1:0] stable;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : gen_debounce
        player_input_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .button(buttons[i]),
            .level (stable[i])
        );
    end

    state_e                 stateQ, stateD;
    logic [1:0]             playerNumQ, playerNumD;
    logic                   pressQ, pressD;
    logic [NUM_BUTTONS-1:0] lampsQ, lampsD;

    logic       anyHigh;
    logic       blocked;
    logic [1:0] stableIdx;

    assign anyHigh = |stable;
    assign blocked = simonTurn | gameOver;

    always_comb begin
        stableIdx = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (stable[i]) begin
                stableIdx = 2'(i);
            end
        end
    end

    always_comb begin
        stateD     = stateQ;
        playerNumD = playerNumQ;
        pressD     = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (anyHigh) begin
                    if (!blocked && $onehot(stable)) begin
                        playerNumD = stableIdx;
                        pressD     = 1'b1;
                        stateD     = StHeld;
                    end else begin
                        stateD = StReleaseWait;
                    end
                end
            end
            StHeld: begin
                // Extra buttons while held are simply ignored until everything is released.
                if (blocked) begin
                    stateD = StReleaseWait;
                end else if (!anyHigh) begin
                    stateD = StIdle;
                end
            end
            StReleaseWait: begin
                if (!anyHigh) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        lampsD = LAMPS_ALL_OFF;
        if (gameOver) begin
            lampsD = LAMPS_ALL_ON;
        end else if (simonTurn && simonPressed) begin
            lampsD = oneHot(simonNum);
        end else if (stateQ == StHeld) begin
            lampsD = oneHot(playerNumQ);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= StIdle;
            playerNumQ <= '0;
            pressQ     <= 1'b0;
            lampsQ     <= LAMPS_ALL_OFF;
        end else begin
            stateQ     <= stateD;
            playerNumQ <= playerNumD;
            pressQ     <= pressD;
            lampsQ     <= lampsD;
        end
    end

    assign playerNum     = playerNumQ;
    assign playerPressed = pressQ;
    assign lamps         = lampsQ;

endmodule

// File: tb/tb_player_input.sv
// Randomized and directed bench for player_input against a cycle-level behavioural model.
module tb_player_input;

    localparam int D = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] buttons;
    logic       simonTurn;
    logic [1:0] simonNum;
    logic       simonPressed;
    logic       gameOver;
    logic [1:0] playerNum;
    logic       playerPressed;
    logic [3:0] lamps;

    player_input #(
        .DEBOUNCE_TICKS(D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .buttons      (buttons),
        .simonTurn    (simonTurn),
        .simonNum     (simonNum),
        .simonPressed (simonPressed),
        .gameOver     (gameOver),
        .playerNum    (playerNum),
        .playerPressed(playerPressed),
        .lamps        (lamps)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Behavioural model: a button counts as pressed once its raw level, seen two clocks late,
    // has disagreed with the accepted level on D+1 successive clock edges.
    bit [3:0] rawSeen1, rawSeen2, mLevel;
    int       mRun[4];
    int       mMode;   // 0: waiting for a press, 1: press owned by player, 2: wait for release
    bit [1:0] mNum;
    bit       mStrobe;
    bit [3:0] mLamps;
    bit       prevStrobe;

    task automatic modelEdge();
        bit [3:0] nextLamps;
        if (reset) begin
            rawSeen1 = 0; rawSeen2 = 0; mLevel = 0; mMode = 0; mNum = 0; mStrobe = 0; mLamps = 0;
            for (int i = 0; i < 4; i++) mRun[i] = 0;
            return;
        end
        if (gameOver) nextLamps = 4'hF;
        else if (simonTurn && simonPressed) nextLamps = 4'(1 << simonNum);
        else if (mMode == 1) nextLamps = 4'(1 << mNum);
        else nextLamps = 0;
        mLamps  = nextLamps;
        mStrobe = 0;
        if (mMode == 0) begin
            if (mLevel != 0) begin
                if (!simonTurn && !gameOver && $countones(mLevel) == 1) begin
                    for (int i = 0; i < 4; i++) if (mLevel[i]) mNum = 2'(i);
                    mStrobe = 1;
                    mMode   = 1;
                end else begin
                    mMode = 2;
                end
            end
        end else if (mMode == 1) begin
            if (simonTurn || gameOver) mMode = 2;
            else if (mLevel == 0) mMode = 0;
        end else begin
            if (mLevel == 0) mMode = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (rawSeen2[i] != mLevel[i]) begin
                mRun[i]++;
                if (mRun[i] == D + 1) begin
                    mLevel[i] = rawSeen2[i];
                    mRun[i]   = 0;
                end
            end else begin
                mRun[i] = 0;
            end
        end
        rawSeen2 = rawSeen1;
        rawSeen1 = buttons;
    endtask

    int strobes;

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkVal("strobe", playerPressed, mStrobe);
        checkVal("num", playerNum, mNum);
        checkVal("lamps", lamps, mLamps);
        checkVal("no_back_to_back", prevStrobe & playerPressed, 0);
        prevStrobe = playerPressed;
        strobes += playerPressed;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        reset = 1; buttons = 0; simonTurn = 0; simonNum = 0; simonPressed = 0; gameOver = 0;
        prevStrobe = 0; strobes = 0;
        steps(2);
        checkVal("rst_num", playerNum, 0);
        checkVal("rst_press", playerPressed, 0);
        checkVal("rst_lamps", lamps, 0);

        // Single press latency: strobe only after edge 6.
        reset = 0; buttons = 4'b0100;
        for (int e = 0; e < 10; e++) begin
            step();
            checkVal("latency", playerPressed, (e == 6) ? 1 : 0);
            if (e == 8) checkVal("held_lamps", lamps, 4'b0100);
        end
        checkVal("latency_num", playerNum, 2);
        buttons = 0; steps(8);

        // Bouncing bit 0 never accepted.
        reset = 1; step(); reset = 0;
        strobes = 0;
        for (int e = 0; e < 20; e++) begin
            buttons[0] = ~buttons[0];
            step();
        end
        checkVal("bounce_strobes", strobes, 0);
        checkVal("bounce_num", playerNum, 0);
        buttons = 0; steps(8);

        // Simultaneous pair rejected, then a clean single press accepted.
        strobes = 0; buttons = 4'b0011; steps(10);
        checkVal("pair_strobes", strobes, 0);
        buttons = 0; steps(8);
        buttons = 4'b0010; steps(10);
        checkVal("single_strobes", strobes, 1);
        checkVal("single_num", playerNum, 1);
        buttons = 0; steps(8);

        // Held across the end of the sequencer turn: must be released first.
        strobes = 0; simonTurn = 1; buttons = 4'b1000; steps(10);
        simonTurn = 0; steps(10);
        checkVal("turn_hold_strobes", strobes, 0);
        buttons = 0; steps(8);
        buttons = 4'b1000; steps(10);
        checkVal("turn_repress_strobes", strobes, 1);
        checkVal("turn_repress_num", playerNum, 3);
        buttons = 0; steps(8);

        // Lamp priority and game over lockout.
        simonTurn = 1; simonPressed = 1; simonNum = 2'b01; step();
        checkVal("simon_lamps", lamps, 4'b0010);
        simonTurn = 0; simonPressed = 0; gameOver = 1; step();
        checkVal("over_lamps", lamps, 4'b1111);
        strobes = 0; buttons = 4'b0001; steps(10);
        checkVal("over_strobes", strobes, 0);
        buttons = 0; steps(8); gameOver = 0; steps(2);

        // Reset during a press, button still held afterwards: fresh debounce from release.
        strobes = 0; buttons = 4'b0100; steps(4);
        reset = 1; steps(2);
        checkVal("mid_reset_num", playerNum, 0);
        reset = 0;
        for (int e = 0; e < 10; e++) begin
            step();
            checkVal("post_reset_latency", playerPressed, (e == 6) ? 1 : 0);
        end
        buttons = 0; steps(8);
        buttons = 4'b0001; steps(10);
        checkVal("post_reset_strobes", strobes, 2);
        checkVal("post_reset_num", playerNum, 0);
        buttons = 0; steps(8);

        // Random phase: held patterns (mostly single buttons), glitches and mode changes.
        for (int blk = 0; blk < 400; blk++) begin
            int r = $urandom_range(0, 99);
            int len = $urandom_range(1, 12);
            if (r < 45) buttons = 4'(1 << $urandom_range(0, 3));
            else if (r < 70) buttons = 0;
            else buttons = 4'($urandom_range(0, 15));
            simonTurn    = ($urandom_range(0, 9) == 0);
            simonPressed = $urandom_range(0, 1) != 0;
            simonNum     = 2'($urandom_range(0, 3));
            gameOver     = ($urandom_range(0, 29) == 0);
            reset        = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < len; k++) begin
                step();
                reset = 0;
                if ($urandom_range(0, 19) == 0) buttons[$urandom_range(0, 3)] ^= 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_input.md
PLAYER_INPUT -- requirements
Module: player_input

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 3: consecutive clk cycles a synchronized button level must hold before it counts as stable.
REQ-002 clk  input  1  system clock, 60 Hz game tick.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 buttons  input  4  raw asynchronous push-buttons, bit i = colour i, active-high.
REQ-005 simonTurn  input  1  high while the sequencer is playing its pattern; player input ignored.
REQ-006 simonNum  input  2  colour the sequencer is currently showing.
REQ-007 simonPressed  input  1  high while the sequencer "holds" simonNum.
REQ-008 gameOver  input  1  high after the game ends; player input ignored.
REQ-009 playerNum  output  2  encoded colour of the last accepted press; held until the next accepted press.
REQ-010 playerPressed  output  1  single-cycle strobe, one per accepted press.
REQ-011 lamps  output  4  one-hot colour lamp drive.

Function
REQ-012 Each buttons bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Debounced level of bit i SHALL change only after its synchronized value has differed from the current debounced level for DEBOUNCE_TICKS consecutive cycles; any mismatch-free cycle restarts the count.
REQ-014 FSM states: IDLE, HELD, RELEASE_WAIT; all transitions on posedge clk.
REQ-015 IDLE: all debounced low and simonTurn=0 and gameOver=0; exactly one debounced bit rising -> latch its index into playerNum, assert playerPressed for one cycle, go HELD.
REQ-016 IDLE: two or more debounced bits high in the same cycle -> no strobe, playerNum unchanged, go RELEASE_WAIT.
REQ-017 HELD: any additional button becoming debounced high -> no further strobe; all debounced low -> IDLE.
REQ-018 RELEASE_WAIT: stay until all debounced bits are low, then IDLE.
REQ-019 Any debounced bit high while simonTurn=1 or gameOver=1 -> no strobe, go RELEASE_WAIT; a button held across the turn change SHALL be released before it can be accepted.
REQ-020 simonTurn or gameOver rising while in HELD -> go RELEASE_WAIT; no strobe.
REQ-021 Latency: button held steadily from edge 0 -> playerPressed high exactly in the cycle following edge 2+DEBOUNCE_TICKS+1 (edge 6 with default), for one cycle.
REQ-022 playerPressed SHALL never be high on two consecutive cycles.
REQ-023 lamps: gameOver=1 -> 4'b1111; else simonTurn=1 and simonPressed=1 -> one-hot of simonNum; else state HELD -> one-hot of playerNum; else 4'b0000. lamps registered, one cycle after its inputs.
REQ-024 Debounce counters SHALL saturate, never wrap, at DEBOUNCE_TICKS.

Reset
REQ-025 On reset=1 at posedge clk: state IDLE, playerPressed 0, playerNum 2'b00, lamps 4'b0000, synchronizers, debounced levels, and counters cleared.
REQ-026 Reset mid-press SHALL produce no strobe; a button still held after reset deasserts SHALL debounce fresh and is accepted only from IDLE per REQ-015 (goes through normal debounce, counted from reset release).

Structure
REQ-027 Shared package holds NUM_BUTTONS=4, the FSM state encoding, and the lamp all-on constant.
REQ-028 One sub-module, debounce (synchronizer + counter + stable level, parameterized by DEBOUNCE_TICKS), instantiated NUM_BUTTONS times.

Verification
REQ-029 Reset, simonTurn=0, buttons=4'b0100 held from edge 0 -> playerPressed=1 only in cycle after edge 6, playerNum=2'b10, lamps=4'b0100 while held.
REQ-030 buttons bit 0 toggling every cycle for 20 cycles -> no playerPressed, playerNum stays 2'b00.
REQ-031 buttons=4'b0011 pressed on the same edge -> no strobe; after release then 4'b0010 -> one strobe, playerNum=2'b01.
REQ-032 buttons=4'b1000 held while simonTurn=1, simonTurn falls while still held -> no strobe until release and re-press; re-press -> one strobe, playerNum=2'b11.
REQ-033 simonTurn=1, simonPressed=1, simonNum=2'b01 -> lamps=4'b0010 next cycle; gameOver=1 -> lamps=4'b1111, any press gives no strobe.
REQ-034 reset asserted during a held press then released with button still held -> no strobe until debounced from reset release; after release and re-press, normal single strobe.
